// File: rtl/two_phase_tx.sv
// two_phase_tx
// Clocked sender (initiator) side of a two-phase, transition-signalled
// bundled-data handshake. Words are taken from a synchronous valid/ready
// source and driven onto Data_out. After a setup delay, Req_out toggles.
// Each toggle of the asynchronous Ack_in completes one transfer.
//
// Ports
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   S_valid      in   1       source word valid
//   S_ready      out  1       block can accept a word
//   S_data       in   DATA_W  source word
//   Req_out      out  1       two-phase request, one transition per word
//   Ack_in       in   1       two-phase acknowledge (asynchronous)
//   Data_out     out  DATA_W  bundled data, stable while a request is open
//   Busy         out  1       high whenever the FSM is not in IDLE
//   Err_clr      in   1       synchronous clear of Timeout_err
//   Timeout_err  out  1       sticky: acknowledge not seen in time
//   Xfer_count   out  16      completed transfers, wraps silently
module two_phase_tx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int SETUP_CYC   = 1,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              S_valid,
   output logic              S_ready,
   input  logic [DATA_W-1:0] S_data,
   output logic              Req_out,
   input  logic              Ack_in,
   output logic [DATA_W-1:0] Data_out,
   output logic              Busy,
   input  logic              Err_clr,
   output logic              Timeout_err,
   output logic [15:0]       Xfer_count
);

   localparam int SCW = (SETUP_CYC < 2) ? 1 : $clog2(SETUP_CYC);
   localparam int TCW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam int RCW = $clog2(SYNC_STAGES + 1);
   localparam logic [SCW-1:0] SC_LAST = SCW'(SETUP_CYC - 1);
   localparam logic [TCW-1:0] T_LAST  = TCW'(TIMEOUT_CYC - 1);
   localparam logic [TCW-1:0] T_MAX   = TCW'(TIMEOUT_CYC);
   localparam logic [RCW-1:0] RC_DONE = RCW'(SYNC_STAGES);
   localparam logic           TMO_EN  = (TIMEOUT_CYC != 0);

   typedef enum logic [1:0] {
      RESYNC   = 2'd0,
      IDLE     = 2'd1,
      SETUP    = 2'd2,
      WAIT_ACK = 2'd3
   } state_t;

   state_t                 state_r, state_nxt_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   ack_s;
   logic [SCW-1:0]         cnt_r, cnt_nxt_s;
   logic [TCW-1:0]         tcnt_r, tcnt_nxt_s;
   logic [RCW-1:0]         rcnt_r, rcnt_nxt_s;
   logic                   req_nxt_s, s_ready_nxt_s, tmo_set_s, terr_nxt_s;
   logic [DATA_W-1:0]      data_nxt_s;
   logic [15:0]            xfer_nxt_s;

   assign ack_s = sync_r[SYNC_STAGES-1];

   // Next-state and next-output logic for the handshake FSM.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      tcnt_nxt_s    = tcnt_r;
      rcnt_nxt_s    = rcnt_r;
      req_nxt_s     = Req_out;
      data_nxt_s    = Data_out;
      s_ready_nxt_s = 1'b0;
      xfer_nxt_s    = Xfer_count;
      tmo_set_s     = 1'b0;
      case (state_r)
         RESYNC: begin
            // The synchronizer comes out of reset at 0, so its output is
            // only trusted once it has been fully refilled from Ack_in.
            if (rcnt_r != RC_DONE) begin
               rcnt_nxt_s = rcnt_r + RCW'(1);
            end else begin
               rcnt_nxt_s = rcnt_r;
            end
            if ((rcnt_r == RC_DONE) && (ack_s == Req_out)) begin
               state_nxt_s   = IDLE;
               s_ready_nxt_s = 1'b1;
            end else begin
               state_nxt_s = RESYNC;
            end
         end
         IDLE: begin
            if (S_valid && S_ready) begin
               data_nxt_s  = S_data;
               cnt_nxt_s   = '0;
               state_nxt_s = SETUP;
            end else begin
               // A stray ack transition leaves the phases unequal; hold off
               // the source until the receiver is back in step.
               s_ready_nxt_s = (ack_s == Req_out);
            end
         end
         SETUP: begin
            if (cnt_r == SC_LAST) begin
               req_nxt_s   = ~Req_out;
               tcnt_nxt_s  = '0;
               state_nxt_s = WAIT_ACK;
            end else begin
               cnt_nxt_s = cnt_r + SCW'(1);
            end
         end
         WAIT_ACK: begin
            if (ack_s == Req_out) begin
               xfer_nxt_s    = Xfer_count + 16'd1;
               s_ready_nxt_s = 1'b1;
               state_nxt_s   = IDLE;
            end else begin
               // tcnt parks one past the limit so the flag sets only once
               // and Err_clr can clear it while the transfer still waits.
               if (tcnt_r != T_MAX) begin
                  tcnt_nxt_s = tcnt_r + TCW'(1);
               end else begin
                  tcnt_nxt_s = tcnt_r;
               end
               if (TMO_EN && (tcnt_r == T_LAST)) begin
                  tmo_set_s = 1'b1;
               end else begin
                  tmo_set_s = 1'b0;
               end
            end
         end
         default: begin
            state_nxt_s = RESYNC;
         end
      endcase
      if (tmo_set_s) begin
         terr_nxt_s = 1'b1;
      end else if (Err_clr) begin
         terr_nxt_s = 1'b0;
      end else begin
         terr_nxt_s = Timeout_err;
      end
   end

   // State, synchronizer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= RESYNC;
         sync_r      <= '0;
         cnt_r       <= '0;
         tcnt_r      <= '0;
         rcnt_r      <= '0;
         Req_out     <= 1'b0;
         Data_out    <= '0;
         S_ready     <= 1'b0;
         Busy        <= 1'b1;
         Timeout_err <= 1'b0;
         Xfer_count  <= 16'd0;
      end else begin
         state_r     <= state_nxt_s;
         sync_r      <= {sync_r[SYNC_STAGES-2:0], Ack_in};
         cnt_r       <= cnt_nxt_s;
         tcnt_r      <= tcnt_nxt_s;
         rcnt_r      <= rcnt_nxt_s;
         Req_out     <= req_nxt_s;
         Data_out    <= data_nxt_s;
         S_ready     <= s_ready_nxt_s;
         Busy        <= (state_nxt_s != IDLE);
         Timeout_err <= terr_nxt_s;
         Xfer_count  <= xfer_nxt_s;
      end
   end

endmodule
